// File: rtl/usb_txn_scheduler_if.sv
// Bundle of requester-side and host-side signals for the two-requester USB transaction scheduler.
// The slave modport is the scheduler's view. The master modport is the requester/host environment's view.
interface usb_txn_scheduler_if;
  logic [1:0]  req;
  logic [3:0]  req_mode0;
  logic [3:0]  req_mode1;
  logic [63:0] req_wdata0;
  logic [63:0] req_wdata1;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        err;
  logic [63:0] rdata;
  logic        host_read;
  logic        host_write;
  logic [3:0]  host_mode;
  logic [3:0]  host_data_in;
  logic [1:0]  host_status;
  logic [3:0]  host_data_indx;
  logic [3:0]  host_data_out;

  modport master (
    output req, req_mode0, req_mode1, req_wdata0, req_wdata1,
    output host_status, host_data_indx, host_data_out,
    input  grant, done, err, rdata,
    input  host_read, host_write, host_mode, host_data_in
  );

  modport slave (
    input  req, req_mode0, req_mode1, req_wdata0, req_wdata1,
    input  host_status, host_data_indx, host_data_out,
    output grant, done, err, rdata,
    output host_read, host_write, host_mode, host_data_in
  );
endinterface

// File: rtl/usb_txn_scheduler.sv
// Round-robin scheduler that serialises two requesters onto a nibble-wide host port.
// Each transaction is: 16-nibble write, wait for status, 16-nibble indexed read, then a one-cycle completion.
module usb_txn_scheduler #(
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  usb_txn_scheduler_if.slave bus
);

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT   = 3'd2,
    FETCH  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t      state;
  logic        last;
  logic        sticky;
  logic [3:0]  k;
  logic [3:0]  k_nxt;
  logic [15:0] tcnt;
  logic [3:0]  mode_q;
  logic [63:0] wdata_q;
  logic [63:0] fbuf;
  logic [63:0] fetch_buf;
  logic        pick;
  logic        nib_bad;
  logic [3:0]  sel_mode;
  logic [63:0] sel_wdata;

  logic [1:0]  grant_q;
  logic [1:0]  done_q;
  logic        err_q;
  logic [63:0] rdata_q;
  logic        host_read_q;
  logic        host_write_q;
  logic [3:0]  host_mode_q;
  logic [3:0]  host_data_in_q;

  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.host_read    = host_read_q;
  assign bus.host_write   = host_write_q;
  assign bus.host_mode    = host_mode_q;
  assign bus.host_data_in = host_data_in_q;

  // On a tie the requester that was not served last wins; a lone requester always wins.
  always_comb begin
    pick      = (bus.req == 2'b11) ? ~last : bus.req[1];
    sel_mode  = pick ? bus.req_mode1 : bus.req_mode0;
    sel_wdata = pick ? bus.req_wdata1 : bus.req_wdata0;
    k_nxt     = k + 4'd1;
    nib_bad   = (bus.host_data_indx != k);
    fetch_buf = fbuf;
    fetch_buf[{k, 2'b00} +: 4] = bus.host_data_out;
  end

  // Payload holding registers carry no control meaning and need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req != 2'b00) begin
      mode_q  <= sel_mode;
      wdata_q <= sel_wdata;
    end
    if (state == FETCH) begin
      fbuf <= fetch_buf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last           <= 1'b1;
      sticky         <= 1'b0;
      k              <= 4'd0;
      tcnt           <= 16'd0;
      grant_q        <= 2'b00;
      done_q         <= 2'b00;
      err_q          <= 1'b0;
      rdata_q        <= 64'd0;
      host_read_q    <= 1'b0;
      host_write_q   <= 1'b0;
      host_mode_q    <= 4'd0;
      host_data_in_q <= 4'd0;
    end else begin
      done_q <= 2'b00;
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            state          <= LOAD;
            last           <= pick;
            grant_q        <= pick ? 2'b10 : 2'b01;
            sticky         <= 1'b0;
            k              <= 4'd0;
            tcnt           <= 16'd0;
            host_write_q   <= 1'b1;
            host_mode_q    <= sel_mode;
            host_data_in_q <= sel_wdata[3:0];
          end
        end
        LOAD: begin
          if (k == 4'd15) begin
            state          <= WAIT;
            k              <= 4'd0;
            host_write_q   <= 1'b0;
            host_data_in_q <= 4'd0;
          end else begin
            k              <= k_nxt;
            host_data_in_q <= wdata_q[{k_nxt, 2'b00} +: 4];
          end
        end
        WAIT: begin
          // A definite host answer takes priority over the timeout on the same cycle.
          if (bus.host_status == 2'b01) begin
            state       <= FETCH;
            host_read_q <= 1'b1;
          end else if (bus.host_status[1] || tcnt == TLAST) begin
            state       <= FINISH;
            done_q      <= grant_q;
            err_q       <= 1'b1;
            host_mode_q <= 4'd0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        FETCH: begin
          if (k == 4'd15) begin
            state       <= FINISH;
            host_read_q <= 1'b0;
            host_mode_q <= 4'd0;
            done_q      <= grant_q;
            err_q       <= sticky | nib_bad;
            if (!(sticky | nib_bad)) begin
              rdata_q <= fetch_buf;
            end
          end else begin
            k      <= k_nxt;
            sticky <= sticky | nib_bad;
          end
        end
        FINISH: begin
          state   <= IDLE;
          grant_q <= 2'b00;
          err_q   <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          grant_q      <= 2'b00;
          host_read_q  <= 1'b0;
          host_write_q <= 1'b0;
          host_mode_q  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/usb_txn_scheduler.md
USB_TXN_SCHEDULER -- requirements
Module: usb_txn_scheduler

Interface
REQ-001 Parameter: TIMEOUT, default 1024, maximum cycles spent in WAIT before a transaction is aborted; legal range 2..65535.
REQ-002 clock  in  1  single clock; all flops on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; all state cleared immediately on assertion.
REQ-004 req[1:0]  in  2  transaction request, one bit per requester; level, held until done[i].
REQ-005 req_mode0, req_mode1  in  4 each  host operation mode for requester 0/1; sampled at grant.
REQ-006 req_wdata0, req_wdata1  in  64 each  write payload for requester 0/1; sampled at grant.
REQ-007 grant[1:0]  out  2  one-hot owner of the host; 0 when idle.
REQ-008 done[1:0]  out  2  one-cycle completion pulse to the owner.
REQ-009 err  out  1  valid with done; 1 = aborted (timeout, host error, index mismatch).
REQ-010 rdata  out  64  read payload; valid with done, held until next done.
REQ-011 host_read, host_write  out  1 each  read/write strobes to host.
REQ-012 host_mode  out  4  mode to host.
REQ-013 host_data_in  out  4  write nibble to host.
REQ-014 host_status  in  2  00 busy, 01 ok, 10 error, 11 error.
REQ-015 host_data_indx  in  4  nibble index the host presents.
REQ-016 host_data_out  in  4  read nibble from host.

Function
REQ-017 States: IDLE, LOAD, WAIT, FETCH, FINISH; unused encodings return to IDLE.
REQ-018 IDLE: if any req bit set, grant per round-robin, latch mode/wdata, nibble counter k=0, go LOAD next cycle.
REQ-019 Round-robin: last-served pointer starts at 1 after reset (so requester 0 wins first tie); on a tie the requester not last served wins; a single requester always wins.
REQ-020 grant asserted from the cycle after arbitration through the FINISH cycle inclusive.
REQ-021 host_mode = latched mode in LOAD, WAIT, FETCH; 0 otherwise.
REQ-022 LOAD: 16 cycles, host_write=1, host_data_in = wdata[4k+3:4k], k=0..15 (LSB nibble first); after k=15, k=0, go WAIT.
REQ-023 WAIT: strobes low; timeout counter increments each cycle; status 01 -> FETCH; status 1x -> FINISH with err=1; counter reaching TIMEOUT with status 00 -> FINISH with err=1.
REQ-024 FETCH: 16 cycles, host_read=1; each cycle, if host_data_indx==k, capture host_data_out into rdata[4k+3:4k], else set sticky error flag; after k=15 go FINISH.
REQ-025 FINISH: one cycle; done[owner]=1, err = sticky flag; rdata updated only when err=0; next state IDLE, grant drops.
REQ-026 Min transaction latency: grant to done = 1+16+w+16+1 cycles, w = WAIT cycles (>=1).
REQ-027 Deassertion of req mid-transaction is ignored; transaction runs to FINISH.
REQ-028 host_read and host_write never both 1; strobes are 0 outside LOAD/FETCH.
REQ-029 A requester re-asserting req in the FINISH cycle is eligible in the following IDLE arbitration.

Reset
REQ-030 On reset: state IDLE, grant=0, done=0, err=0, rdata=0, host_read=0, host_write=0, host_mode=0, host_data_in=0, counters 0, RR pointer=1.
REQ-031 Reset asserted mid-transaction aborts it with no done pulse; outputs reach reset values within the same cycle (asynchronously).

Verification
REQ-032 req=01, wdata0=0x0123456789ABCDEF, mode0=0x3, host returns status 01 after 5 cycles and data_indx=k, data_out=0xF-k -> 16 write nibbles F,E,...,0; done[0] at cycle 1+16+5+16+1=39 after grant; err=0; rdata=0x0123456789ABCDEF.
REQ-033 req=11 held continuously -> grants alternate 01,10,01; each done is followed by the other grant.
REQ-034 status held 00, TIMEOUT=8 -> done pulse with err=1 exactly 8 WAIT cycles after LOAD ends; rdata unchanged.
REQ-035 status=10 in WAIT -> immediate FINISH, err=1, no host_read pulses issued.
REQ-036 data_indx wrong at k=7 during FETCH -> all 16 read cycles still issued, err=1, rdata unchanged.
REQ-037 reset asserted at LOAD k=9 -> all outputs zero asynchronously; after release, pending req restarts from k=0 with no spurious done.
